miter_stim_sequencer: RTL and testbench

// Exhaustive-stimulus sequencer and result scorer for a gold/gate miter pair, e.g. gold.adder vs gate.adder.

---
 rtl/miter_stim_sequencer_pkg.sv | 12 +
 rtl/miter_stim_sequencer_if.sv | 31 +++
 rtl/miter_stim_sequencer_cmp_pipe.sv | 52 +++++
 rtl/miter_stim_sequencer.sv | 158 +++++++++++++++
 tb/tb_miter_stim_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/miter_stim_sequencer_pkg.sv
// Shared types for the gold/gate miter stimulus sequencer.
// Sequencer FSM encoding is fixed at 2 bits so it can be probed directly on FPGA.
package miter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/miter_stim_sequencer_if.sv
// Control, stimulus and scoring bundle between a host/miter harness and the sequencer.
// master = host side (drives control and the gold/gate responses), slave = sequencer.
interface miter_stim_sequencer_if #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 2,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             ack;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] gold_out;
    logic [OUT_W-1:0] gate_out;
    logic [OUT_W-1:0] gold_care;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             first_fail_valid;
    logic [IN_W-1:0]  first_fail_vec;

    modport master (
        output start, abort, ack, gold_out, gate_out, gold_care,
        input  stim, busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_vec
    );

    modport slave (
        input  start, abort, ack, gold_out, gate_out, gold_care,
        output stim, busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/miter_stim_sequencer_cmp_pipe.sv
// Delay line that re-aligns each issued vector (and its valid) with the gold/gate
// responses DUT_LAT cycles later; collapses to plain wires when DUT_LAT is 0.
module miter_cmp_pipe #(
    parameter int IN_W    = 2,
    parameter int DUT_LAT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            vld_in,
    input  logic [IN_W-1:0] vec_in,
    output logic            vld_out,
    output logic [IN_W-1:0] vec_out
);

    generate
        if (DUT_LAT == 0) begin : g_comb
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst_n, flush};
            assign vld_out     = vld_in;
            assign vec_out     = vec_in;
        end else begin : g_pipe
            logic [DUT_LAT-1:0] vld_p;
            logic [IN_W-1:0]    vec_p [DUT_LAT];

            // Stage boundary: valid bits are flushed on abort so stale compares never retire.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p <= '0;
                end else if (flush) begin
                    vld_p <= '0;
                end else begin
                    vld_p[0] <= vld_in;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        vld_p[i] <= vld_p[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                vec_p[0] <= vec_in;
                for (int i = 1; i < DUT_LAT; i++) begin
                    vec_p[i] <= vec_p[i-1];
                end
            end

            assign vld_out = vld_p[DUT_LAT-1];
            assign vec_out = vec_p[DUT_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/miter_stim_sequencer.sv
// Exhaustive stimulus sweep for a gold/gate miter pair: drives every input vector once,
// scores responses under the gold care mask and reports a pass/fail verdict by handshake.
module miter_stim_sequencer
    import miter_seq_pkg::*;
#(
    parameter int IN_W    = 2,
    parameter int OUT_W   = 2,
    parameter int DUT_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    miter_stim_sequencer_if.slave  bus
);

    localparam int               DRAIN_W    = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);
    localparam logic [IN_W:0]    LAST_ISSUE = {1'b0, {IN_W{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    function automatic logic vec_fails(input logic [OUT_W-1:0] gold,
                                       input logic [OUT_W-1:0] gate,
                                       input logic [OUT_W-1:0] care);
        return |((gold ^ gate) & care);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    state_e             state_q, state_d;
    logic [IN_W:0]      issue_cnt_q;
    logic [IN_W-1:0]    stim_q;
    logic [DRAIN_W-1:0] drain_cnt_q;
    logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;
    logic               ff_valid_q;
    logic [IN_W-1:0]    ff_vec_q;
    logic               pass_q;

    logic               start_sweep;
    logic               flush;
    logic               last_issue;
    logic               cmp_vld;
    logic [IN_W-1:0]    cmp_vec;
    logic               cmp_hit;

    assign last_issue = (state_q == RUN) && (issue_cnt_q == LAST_ISSUE);

    miter_cmp_pipe #(
        .IN_W    (IN_W),
        .DUT_LAT (DUT_LAT)
    ) u_cmp_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .vld_in  (state_q == RUN),
        .vec_in  (stim_q),
        .vld_out (cmp_vld),
        .vec_out (cmp_vec)
    );

    assign cmp_hit   = cmp_vld && vec_fails(bus.gold_out, bus.gate_out, bus.gold_care);
    assign mis_cnt_d = cmp_hit ? sat_inc(mis_cnt_q) : mis_cnt_q;

    always_comb begin
        state_d     = state_q;
        start_sweep = 1'b0;
        flush       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = RUN;
                    start_sweep = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (last_issue) begin
                    state_d = (DUT_LAT > 0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage boundary: issue side (stim/counters) and score side (mismatch/first-fail/pass).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stim_q      <= '0;
            drain_cnt_q <= '0;
            mis_cnt_q   <= '0;
            ff_valid_q  <= 1'b0;
            ff_vec_q    <= '0;
            pass_q      <= 1'b0;
        end else if (start_sweep) begin
            issue_cnt_q <= '0;
            stim_q      <= '0;
            drain_cnt_q <= '0;
            mis_cnt_q   <= '0;
            ff_valid_q  <= 1'b0;
            ff_vec_q    <= '0;
            pass_q      <= 1'b0;
        end else begin
            if (state_q == RUN && !bus.abort) begin
                issue_cnt_q <= issue_cnt_q + 1'b1;
                // The final vector stays on the bus through DRAIN and DONE.
                if (!last_issue) begin
                    stim_q <= stim_q + 1'b1;
                end
            end
            if (state_q == DRAIN) begin
                drain_cnt_q <= drain_cnt_q + 1'b1;
            end
            mis_cnt_q <= mis_cnt_d;
            if (cmp_hit && !ff_valid_q) begin
                ff_valid_q <= 1'b1;
                ff_vec_q   <= cmp_vec;
            end
            // The last compare retires on the same edge that enters DONE, so use the next count.
            if (state_d == DONE && state_q != DONE) begin
                pass_q <= (mis_cnt_d == '0);
            end
        end
    end

    assign bus.stim             = stim_q;
    assign bus.busy             = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done             = (state_q == DONE);
    assign bus.pass             = pass_q;
    assign bus.mismatch_cnt     = mis_cnt_q;
    assign bus.first_fail_valid = ff_valid_q;
    assign bus.first_fail_vec   = ff_vec_q;

endmodule

// File: tb/tb_miter_stim_sequencer.sv
// Directed bench: half-adder gold vs mutable gate copy on three sequencer configurations.
module tb_miter_stim_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] ha(input logic [1:0] ab);
        return {ab[1] & ab[0], ab[1] ^ ab[0]};
    endfunction

    // 0 identical, 1 sum inverted at a=b=1, 2 carry stuck 0, 3 fully inverted
    function automatic logic [1:0] gate_model(input int mode, input logic [1:0] ab);
        logic [1:0] g;
        g = ha(ab);
        case (mode)
            1:       return (ab == 2'b11) ? (g ^ 2'b01) : g;
            2:       return {1'b0, g[0]};
            3:       return ~g;
            default: return g;
        endcase
    endfunction

    miter_stim_sequencer_if #(.IN_W(2), .OUT_W(2), .CNT_W(16)) if0 ();
    miter_stim_sequencer_if #(.IN_W(2), .OUT_W(2), .CNT_W(16)) if1 ();
    miter_stim_sequencer_if #(.IN_W(3), .OUT_W(2), .CNT_W(2))  if2 ();

    miter_stim_sequencer #(.IN_W(2), .OUT_W(2), .DUT_LAT(0), .CNT_W(16))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    miter_stim_sequencer #(.IN_W(2), .OUT_W(2), .DUT_LAT(2), .CNT_W(16))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    miter_stim_sequencer #(.IN_W(3), .OUT_W(2), .DUT_LAT(0), .CNT_W(2))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    int         mode0 = 0;
    logic [1:0] care0 = 2'b11;
    logic [1:0] d1 = '0;
    logic [1:0] d2 = '0;

    always_ff @(posedge clk) begin
        d1 <= if1.stim;
        d2 <= d1;
    end

    always_comb begin
        if0.gold_out  = ha(if0.stim);
        if0.gate_out  = gate_model(mode0, if0.stim);
        if0.gold_care = care0;
        if1.gold_out  = ha(d2);
        if1.gate_out  = gate_model(2, d2);
        if1.gold_care = 2'b11;
        if2.gold_out  = ha(if2.stim[1:0]);
        if2.gate_out  = gate_model(3, if2.stim[1:0]);
        if2.gold_care = 2'b11;
    end

    typedef struct {
        string      name;
        int         mode;
        logic [1:0] care;
        logic       exp_pass;
        int         exp_cnt;
        logic       exp_ffv;
        int         exp_vec;
    } vec_t;

    vec_t tbl[6];

    task automatic sweep0(input vec_t v);
        int  edges;
        bit  seen;
        mode0 = v.mode;
        care0 = v.care;
        @(negedge clk); if0.start = 1'b1;
        @(negedge clk); if0.start = 1'b0;
        chk({v.name, " busy"}, if0.busy, 1);
        chk({v.name, " stim0"}, if0.stim, 0);
        edges = 1;
        seen  = 0;
        while (!seen && edges < 20) begin
            @(negedge clk);
            edges++;
            if (if0.busy && edges <= 4) chk({v.name, " stim"}, if0.stim, edges - 1);
            if (if0.done) seen = 1;
        end
        chk({v.name, " done_edge"}, edges, 5);
        chk({v.name, " pass"}, if0.pass, v.exp_pass);
        chk({v.name, " cnt"}, if0.mismatch_cnt, v.exp_cnt);
        chk({v.name, " ffv"}, if0.first_fail_valid, v.exp_ffv);
        chk({v.name, " ffvec"}, if0.first_fail_vec, v.exp_vec);
        @(negedge clk);
        chk({v.name, " done_hold"}, if0.done, 1);
        if0.ack = 1'b1;
        @(negedge clk); if0.ack = 1'b0;
        chk({v.name, " done_clr"}, if0.done, 0);
        chk({v.name, " cnt_kept"}, if0.mismatch_cnt, v.exp_cnt);
    endtask

    initial begin
        int  edges;
        int  busy_cycles;
        bit  seen;

        tbl[0] = '{"identical",  0, 2'b11, 1'b1, 0, 1'b0, 0};
        tbl[1] = '{"sum_fault",  1, 2'b11, 1'b0, 1, 1'b1, 3};
        tbl[2] = '{"care_carry", 1, 2'b10, 1'b1, 0, 1'b0, 0};
        tbl[3] = '{"carry_st0",  2, 2'b11, 1'b0, 1, 1'b1, 3};
        tbl[4] = '{"inv_sum",    3, 2'b01, 1'b0, 4, 1'b1, 0};
        tbl[5] = '{"care_none",  3, 2'b00, 1'b1, 0, 1'b0, 0};

        if0.start = 0; if0.abort = 0; if0.ack = 0;
        if1.start = 0; if1.abort = 0; if1.ack = 0;
        if2.start = 0; if2.abort = 0; if2.ack = 0;

        #12;
        chk("rst stim", if0.stim, 0);
        chk("rst busy", if0.busy, 0);
        chk("rst done", if0.done, 0);
        chk("rst pass", if0.pass, 0);
        chk("rst cnt", if0.mismatch_cnt, 0);
        chk("rst ffv", if0.first_fail_valid, 0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 6; i++) sweep0(tbl[i]);

        // DUT_LAT=2, carry stuck at 0
        @(negedge clk); if1.start = 1'b1;
        @(negedge clk); if1.start = 1'b0;
        edges = 1; seen = 0; busy_cycles = if1.busy ? 1 : 0;
        while (!seen && edges < 30) begin
            @(negedge clk);
            edges++;
            if (if1.busy) busy_cycles++;
            if (if1.done) seen = 1;
        end
        chk("lat2 done_edge", edges, 7);
        chk("lat2 busy_cycles", busy_cycles, 6);
        chk("lat2 cnt", if1.mismatch_cnt, 1);
        chk("lat2 ffvec", if1.first_fail_vec, 3);
        chk("lat2 pass", if1.pass, 0);
        if1.ack = 1'b1;
        @(negedge clk); if1.ack = 1'b0;

        // IN_W=3, 2-bit counter saturates
        @(negedge clk); if2.start = 1'b1;
        @(negedge clk); if2.start = 1'b0;
        edges = 1; seen = 0;
        while (!seen && edges < 30) begin
            @(negedge clk);
            edges++;
            if (if2.done) seen = 1;
        end
        chk("sat done_edge", edges, 9);
        chk("sat cnt", if2.mismatch_cnt, 3);
        chk("sat ffv", if2.first_fail_valid, 1);
        chk("sat ffvec", if2.first_fail_vec, 0);
        chk("sat pass", if2.pass, 0);
        if2.ack = 1'b1;
        @(negedge clk); if2.ack = 1'b0;

        // abort at stim=2
        mode0 = 0; care0 = 2'b11;
        @(negedge clk); if0.start = 1'b1;
        @(negedge clk); if0.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort stim_at", if0.stim, 2);
        if0.abort = 1'b1;
        @(negedge clk); if0.abort = 1'b0;
        chk("abort busy", if0.busy, 0);
        chk("abort done", if0.done, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (if0.done) seen = 1;
        end
        chk("abort no_done", seen, 0);
        if0.ack = 1'b1; if0.abort = 1'b1;
        @(negedge clk); if0.ack = 1'b0; if0.abort = 1'b0;
        chk("idle ack busy", if0.busy, 0);
        chk("idle ack done", if0.done, 0);

        // restart, start ignored in RUN, then async reset mid-sweep
        mode0 = 3;
        if0.start = 1'b1;
        @(negedge clk); if0.start = 1'b0;
        chk("restart stim0", if0.stim, 0);
        if0.start = 1'b1;
        @(negedge clk); if0.start = 1'b0;
        chk("run start_ign stim1", if0.stim, 1);
        @(negedge clk);
        chk("run start_ign stim2", if0.stim, 2);
        chk("pre_rst cnt", if0.mismatch_cnt, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst stim", if0.stim, 0);
        chk("arst busy", if0.busy, 0);
        chk("arst cnt", if0.mismatch_cnt, 0);
        chk("arst ffv", if0.first_fail_valid, 0);
        chk("arst lat2 ffvec", if1.first_fail_vec, 0);
        chk("arst lat2 cnt", if1.mismatch_cnt, 0);
        chk("arst sat cnt", if2.mismatch_cnt, 0);
        if0.start = 1'b1; if0.ack = 1'b1;
        @(negedge clk);
        chk("rst start_ign busy", if0.busy, 0);
        if0.start = 1'b0; if0.ack = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst busy", if0.busy, 0);
        chk("post_rst done", if0.done, 0);
        chk("post_rst pass", if0.pass, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
